// File: rtl/conway_pkg.sv
// conway_pkg: shared FSM state type, neighbour-count width and the life rule.
package conway_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT, DONE} gen_state_t;
  localparam int CNT_W = 4;
  function automatic logic next_cell(input logic alive, input logic [CNT_W-1:0] count);
    return count == CNT_W'(3) || (alive && count == CNT_W'(2));
  endfunction
endpackage

// File: rtl/row_evaluator.sv
// row_evaluator: next-generation value of one row from its two neighbour rows.
module row_evaluator
  import conway_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] row_next
);
  logic [WIDTH+1:0] a, m, b;
  assign a = {1'b0, above, 1'b0};
  assign m = {1'b0, cur, 1'b0};
  assign b = {1'b0, below, 1'b0};
  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    logic [CNT_W-1:0] n;
    assign n = CNT_W'(a[c]) + CNT_W'(a[c+1]) + CNT_W'(a[c+2]) + CNT_W'(m[c]) + CNT_W'(m[c+2])
             + CNT_W'(b[c]) + CNT_W'(b[c+1]) + CNT_W'(b[c+2]);
    assign row_next[c] = next_cell(m[c+1], n);
  end
endmodule

// File: rtl/generation_engine.sv
// generation_engine: computes the next Conway generation one row per clock and commits it.
module generation_engine
  import conway_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  localparam int N = WIDTH * HEIGHT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] grid_state,
  input  logic         load_run,
  input  logic         start,
  output logic [N-1:0] grid_next,
  output logic         write_enable,
  output logic         busy,
  output logic         done,
  output logic [15:0]  generation
);
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);
  gen_state_t state, nxt;
  logic [N-1:0] snapshot;
  logic [RW-1:0] row_cnt;
  logic [WIDTH-1:0] above, cur, below, row_next;
  // The snapshot decouples evaluation from grid_state, which changes as soon as memory commits.
  assign cur   = WIDTH'(snapshot >> (int'(row_cnt) * WIDTH));
  assign above = row_cnt == '0 ? '0 : WIDTH'(snapshot >> ((int'(row_cnt) - 1) * WIDTH));
  assign below = row_cnt == LAST ? '0 : WIDTH'(snapshot >> ((int'(row_cnt) + 1) * WIDTH));
  row_evaluator #(.WIDTH(WIDTH)) u_row (
    .above   (above),
    .cur     (cur),
    .below   (below),
    .row_next(row_next)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = (start && load_run) ? COMPUTE : IDLE;
      COMPUTE: nxt = !load_run ? IDLE : (row_cnt == LAST ? COMMIT : COMPUTE);
      COMMIT:  nxt = load_run ? DONE : IDLE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  // Strobes are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_next    <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      generation   <= '0;
      snapshot     <= '0;
      row_cnt      <= '0;
    end else begin
      write_enable <= nxt == COMMIT;
      busy         <= nxt == COMPUTE || nxt == COMMIT;
      done         <= nxt == DONE;
      if (state == IDLE && nxt == COMPUTE) begin
        snapshot <= grid_state;
        row_cnt  <= '0;
      end
      if (state == COMPUTE && load_run) begin
        grid_next[int'(row_cnt) * WIDTH +: WIDTH] <= row_next;
        row_cnt <= row_cnt == LAST ? row_cnt : row_cnt + 1'b1;
      end
      if (state == COMMIT && nxt == DONE) generation <= generation + 16'd1;
    end
  end
endmodule

// File: tb/tb_generation_engine.sv
// tb_generation_engine: scoreboard bench for generation_engine on a 5x5 grid.
module tb_generation_engine;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_run = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] grid_state = '0;
  logic [N-1:0] grid_next;
  logic write_enable, busy, done;
  logic [15:0] generation;
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_grid[$];
  logic [15:0] exp_gen[$];
  logic [15:0] gen_model = '0;

  always #5 clk = ~clk;

  generation_engine #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .grid_state  (grid_state),
    .load_run    (load_run),
    .start       (start),
    .grid_next   (grid_next),
    .write_enable(write_enable),
    .busy        (busy),
    .done        (done),
    .generation  (generation)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] life(input logic [N-1:0] g);
    logic [N-1:0] r;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < H && x + dx >= 0 && x + dx < W)
              n += int'(g[(y + dy) * W + x + dx]);
        r[y * W + x] = (n == 3) || (g[y * W + x] && n == 2);
      end
    return r;
  endfunction

  task automatic push(input logic [N-1:0] e);
    gen_model = gen_model + 16'd1;
    exp_grid.push_back(e);
    exp_gen.push_back(gen_model);
  endtask

  // Called just after the accepting edge; waits for the commit and checks it against the queue.
  task automatic finish_step(input string tag);
    int n;
    logic [N-1:0] eg;
    logic [15:0] eq;
    n = 0;
    do begin
      tick;
      n++;
    end while (!write_enable && n < 20);
    check({tag, "_lat"}, n, H);
    eg = exp_grid.pop_front();
    eq = exp_gen.pop_front();
    check({tag, "_grid"}, grid_next, eg);
    tick;
    check({tag, "_done"}, done, 1);
    check({tag, "_we_off"}, write_enable, 0);
    check({tag, "_gen"}, generation, eq);
    tick;
    check({tag, "_done_off"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic step(input string tag, input logic [N-1:0] g, input logic [N-1:0] e);
    grid_state = g;
    load_run = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    push(e);
    grid_state = ~g;
    finish_step(tag);
  endtask

  initial begin
    int we_n, dn_n, k;
    logic [N-1:0] g;
    tick;
    tick;
    check("rst_grid", grid_next, 0);
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gen", generation, 0);
    reset = 1'b0;
    tick;

    // async reset two cycles into a step
    grid_state = 25'h0000063;
    load_run = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("mid_rst_grid", grid_next, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", write_enable, 0);
    tick;
    reset = 1'b0;
    we_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      we_n += int'(write_enable);
    end
    check("mid_rst_no_we", we_n, 0);
    check("mid_rst_gen", generation, 0);

    step("blinker", 25'h0021080, 25'h0003800);
    step("block", 25'h0000063, 25'h0000063);
    step("single", 25'h0001000, 25'h0000000);
    for (int i = 0; i < 4; i++) begin
      g = N'($urandom);
      step("rand", g, life(g));
    end

    load_run = 1'b0;
    start = 1'b1;
    we_n = 0;
    dn_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      we_n += int'(write_enable);
      dn_n += int'(busy);
    end
    start = 1'b0;
    check("gate_busy", dn_n, 0);
    check("gate_we", we_n, 0);

    // start held high across a whole step
    grid_state = 25'h0021080;
    load_run = 1'b1;
    start = 1'b1;
    tick;
    push(25'h0003800);
    we_n = 0;
    k = 0;
    while (!done && k < 20) begin
      tick;
      k++;
      we_n += int'(write_enable);
    end
    check("held_we_cnt", we_n, 1);
    check("held_done", done, 1);
    check("held_busy_done", busy, 0);
    check("held_grid", grid_next, exp_grid.pop_front());
    check("held_gen", generation, exp_gen.pop_front());
    tick;
    check("held_ignored_in_done", busy, 0);
    tick;
    check("held_rearm", busy, 1);
    start = 1'b0;
    push(25'h0003800);
    finish_step("rearm");

    // abort by dropping load_run mid-compute
    grid_state = 25'h0001000;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    load_run = 1'b0;
    tick;
    check("abort_idle", busy, 0);
    we_n = 0;
    dn_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      we_n += int'(write_enable);
      dn_n += int'(done);
    end
    check("abort_we", we_n, 0);
    check("abort_done", dn_n, 0);
    check("abort_gen", generation, gen_model);

    force dut.generation = 16'hFFFE;
    #1;
    release dut.generation;
    gen_model = 16'hFFFE;
    step("wrap1", 25'h0000063, 25'h0000063);
    step("wrap2", 25'h0021080, 25'h0003800);
    check("wrap_zero", generation, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
